// File: rtl/mysoc_pkg.sv
// Shared definitions for the mysoc RV32I pipeline: data width, reset vector
// and the {pc, instruction} packet passed from fetch to decode.
package mysoc_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer between the fetch response path and decode.
// Head is read combinationally; flush wins over push.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage is deliberately not reset; validity lives in count, so a
  // reset here would only add fan-out to every data flop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst || flush) push |-> (!full || pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst || flush) pop |-> !empty);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues in-order word fetches under a credit limit,
// tags returned words with their PC, and drops fetches made stale by redirects.
module if_stage
  import mysoc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instruction
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_aligned;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occ;
  logic            fifo_full;
  logic            fifo_empty;
  logic            req_fire;
  logic            id_fire;
  logic            rsp_keep;
  logic            unused_lsbs;
  fetch_pkt_t      push_pkt;
  fetch_pkt_t      head_pkt;

  assign redirect_aligned = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_lsbs      = ^redirect_pc[1:0];

  assign id_valid = !rst && !fifo_empty && !redirect_valid;
  assign id_fire  = id_valid && id_ready;

  // Occupancy counts fetches in flight plus buffered words, crediting a pop
  // this cycle, so every future response is guaranteed a FIFO slot.
  assign occ            = {1'b0, outstanding} + {1'b0, fifo_count} - (CW+1)'(id_fire);
  assign imem_req_valid = !rst && !redirect_valid && (occ < {1'b0, DEPTH_C});
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep = imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;
  assign push_pkt = '{pc: rsp_pc, instr: imem_rsp_data};

  assign id_pc          = fifo_empty ? '0 : head_pkt.pc;
  assign id_instruction = fifo_empty ? '0 : head_pkt.instr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (id_fire),
    .flush (redirect_valid),
    .din   (push_pkt),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .dout  (head_pkt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Every fetch still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_aligned;
      rsp_pc      <= redirect_aligned;
      outstanding <= outstanding - CW'(imem_rsp_valid);
      drop_cnt    <= outstanding - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid) begin
        if (drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
        else                rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding != '0));
  a_credit_limit:  assert property (@(posedge clk) disable iff (rst)
    ({1'b0, outstanding} + {1'b0, fifo_count}) <= {1'b0, DEPTH_C});
  a_push_has_room: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> (!fifo_full || id_fire));
  a_drop_bounded:  assert property (@(posedge clk) disable iff (rst)
    drop_cnt <= outstanding);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a transaction-level model (in-flight fetches tagged
// with a redirect epoch, plus an expected buffer queue) checked every cycle.
module tb_if_stage;
  import mysoc_pkg::*;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] RST_PC2 = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instruction;

  logic        b_req_valid;
  logic [31:0] b_req_addr;
  logic        b_rsp_valid;
  logic [31:0] b_rsp_data;
  logic        b_id_valid;
  logic [31:0] b_id_pc, b_id_instr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int mem_lat = 1;

  typedef struct { int due; logic [31:0] addr; } mem_ent_t;
  typedef struct { logic [31:0] addr; int epoch; } infl_t;
  typedef struct { int cyc; logic [31:0] val; } log_t;

  mem_ent_t   memq[$];
  infl_t      inflight[$];
  fetch_pkt_t mbuf[$];
  log_t       req_log[$], id_log[$], b_req_log[$], b_id_log[$];

  logic [31:0] exp_fetch_pc;
  int          epoch = 0;
  logic        b_pend;
  logic [31:0] b_pend_addr;

  if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_instruction(id_instruction)
  );

  if_stage #(.RESET_PC(RST_PC2), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(b_req_valid), .imem_req_ready(1'b1),
    .imem_req_addr(b_req_addr),
    .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(b_id_valid), .id_ready(1'b1),
    .id_pc(b_id_pc), .id_instruction(b_id_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Memories: respond after mem_lat cycles (main) or 1 cycle (wrap instance).
  always @(posedge clk) begin
    #1;
    cyc++;
    if (memq.size() > 0 && memq[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      void'(memq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    b_rsp_valid = b_pend;
    b_rsp_data  = mem_word(b_pend_addr);
  end

  // Model and per-cycle compare.
  logic       e_id_valid, e_id_fire, e_req_valid;
  fetch_pkt_t e_head;
  infl_t      ent;
  int         occ;

  always @(negedge clk) begin
    if (rst) begin
      check("req_valid_in_rst", 32'(imem_req_valid), 32'd0);
      check("id_valid_in_rst",  32'(id_valid),       32'd0);
      exp_fetch_pc = RST_PC;
      inflight.delete();
      mbuf.delete();
      epoch++;
      b_req_log.delete();
      b_id_log.delete();
    end else begin
      e_id_valid  = (mbuf.size() > 0) && !redirect_valid;
      e_head      = (mbuf.size() > 0) ? mbuf[0] : '0;
      e_id_fire   = e_id_valid && id_ready;
      occ         = inflight.size() + mbuf.size() - (e_id_fire ? 1 : 0);
      e_req_valid = !redirect_valid && (occ < DEPTH);
      check("req_valid", 32'(imem_req_valid), 32'(e_req_valid));
      check("req_addr",  imem_req_addr,       exp_fetch_pc);
      check("id_valid",  32'(id_valid),       32'(e_id_valid));
      check("id_pc",     id_pc,               e_head.pc);
      check("id_instr",  id_instruction,      e_head.instr);
      if (redirect_valid) begin
        exp_fetch_pc = {redirect_pc[31:2], 2'b00};
        epoch++;
        mbuf.delete();
        if (imem_rsp_valid && inflight.size() > 0) void'(inflight.pop_front());
      end else begin
        if (e_id_fire) void'(mbuf.pop_front());
        if (imem_rsp_valid && inflight.size() > 0) begin
          ent = inflight.pop_front();
          if (ent.epoch == epoch) mbuf.push_back('{pc: ent.addr, instr: mem_word(ent.addr)});
        end
        if (e_req_valid && imem_req_ready) begin
          inflight.push_back('{addr: exp_fetch_pc, epoch: epoch});
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      memq.push_back('{due: cyc + mem_lat, addr: imem_req_addr});
      req_log.push_back('{cyc: cyc, val: imem_req_addr});
    end
    if (id_valid && id_ready) id_log.push_back('{cyc: cyc, val: id_pc});
    b_pend      = b_req_valid;
    b_pend_addr = b_req_addr;
    if (b_req_valid) b_req_log.push_back('{cyc: cyc, val: b_req_addr});
    if (b_id_valid)  b_id_log.push_back('{cyc: cyc, val: b_id_pc});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_log.delete();
    id_log.delete();
  endtask

  task automatic do_reset(input int lat);
    rst = 1'b1;
    mem_lat = lat;
    redirect_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    clear_logs();
  endtask

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    b_rsp_valid = 1'b0;
    b_rsp_data = 32'h0;
    b_pend = 1'b0;
    b_pend_addr = 32'h0;
    exp_fetch_pc = RST_PC;

    // 1: streaming with 1-cycle memory; also the wrap-around instance.
    id_ready = 1'b1;
    do_reset(1);
    repeat (8) tick();
    check("t1_req0", req_log[0].val, 32'h0);
    check("t1_req1", req_log[1].val, 32'h4);
    check("t1_req2", req_log[2].val, 32'h8);
    check("t1_id0",  id_log[0].val,  32'h0);
    check("t1_id1",  id_log[1].val,  32'h4);
    check("t1_id2",  id_log[2].val,  32'h8);
    check("t1_latency", 32'(id_log[0].cyc - req_log[0].cyc), 32'd2);
    check("t1_back_to_back", 32'(id_log[2].cyc - id_log[0].cyc), 32'd2);
    check("t5_wrap_req0", b_req_log[0].val, 32'hFFFF_FFF8);
    check("t5_wrap_req1", b_req_log[1].val, 32'hFFFF_FFFC);
    check("t5_wrap_req2", b_req_log[2].val, 32'h0000_0000);
    check("t5_wrap_id2",  b_id_log[2].val,  32'h0000_0000);

    // 2: decode stalls; credit limit caps requests at the FIFO depth.
    id_ready = 1'b0;
    do_reset(1);
    repeat (5) tick();
    @(negedge clk);
    check("t2_req_count", 32'(req_log.size()), 32'(DEPTH));
    check("t2_req_valid", 32'(imem_req_valid), 32'd0);
    check("t2_id_valid",  32'(id_valid), 32'd1);
    check("t2_head_pc",   id_pc, 32'h0);
    tick();
    id_ready = 1'b1;
    repeat (6) tick();
    check("t2_id0", id_log[0].val, 32'h0);
    check("t2_id1", id_log[1].val, 32'h4);
    check("t2_id2", id_log[2].val, 32'h8);

    // 3: 3-cycle memory, redirect with two fetches in flight.
    id_ready = 1'b1;
    do_reset(3);
    repeat (2) tick();
    check("t3_inflight", 32'(req_log.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    @(negedge clk);
    check("t3_no_req_on_redirect", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    repeat (12) tick();
    check("t3_first_req", req_log[0].val, 32'h100);
    check("t3_first_id",  id_log[0].val,  32'h100);
    check("t3_second_id", id_log[1].val,  32'h104);

    // 4: redirect in a cycle with a response arriving and decode ready.
    do_reset(1);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0040;
    @(negedge clk);
    check("t4_id_valid_on_redirect", 32'(id_valid), 32'd0);
    check("t4_rsp_present", 32'(imem_rsp_valid), 32'd1);
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    check("t4_id0", id_log[0].val, 32'h0);
    check("t4_id1", id_log[1].val, 32'h4);
    check("t4_id2", id_log[2].val, 32'h40);
    check("t4_id3", id_log[3].val, 32'h44);

    // 5: back-to-back redirects, last one (unaligned) wins.
    do_reset(1);
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    clear_logs();
    repeat (6) tick();
    check("t5_req_aligned", req_log[0].val, 32'h200);
    check("t5_id_aligned",  id_log[0].val,  32'h200);

    // 6: reset with a full FIFO holding a redirected stream.
    id_ready = 1'b0;
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0080;
    tick();
    redirect_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("t6_full_id_valid", 32'(id_valid), 32'd1);
    check("t6_full_head",     id_pc, 32'h80);
    check("t6_full_no_req",   32'(imem_req_valid), 32'd0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_id_valid",  32'(id_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t6_rst2_id_valid", 32'(id_valid), 32'd0);
    check("t6_rst2_req",      32'(imem_req_valid), 32'd0);
    tick();
    rst = 1'b0;
    id_ready = 1'b1;
    clear_logs();
    repeat (6) tick();
    check("t6_restart_req", req_log[0].val, RST_PC);
    check("t6_restart_id",  id_log[0].val,  RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
